id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/core_pkg.sv | 46 ++++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_reg.sv | 224 ++++++++++++++++++++++
 tb/tb_id_ex_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// Module : core_pkg
// Shared decode types and constants for the decoder and the ID/EX register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  // Field order is fixed because the decoder also uses it. regWrt is the MSB.
  typedef struct packed {
    logic       regWrt;
    logic       memWrt;
    logic       jmp;
    logic       brnch;
    logic       aluSrc;
    logic       read;
    logic [1:0] rsltSrc;
    logic [1:0] ujMux;
    logic [4:0] aluCtrl;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_MULHU  = 5'b01101;

  function automatic logic is_mul(input logic [4:0] alu_ctrl);
    return (alu_ctrl >= ALU_MUL) && (alu_ctrl <= ALU_MULHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Load-use comparator between the load in EX and the source registers in ID.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  logic w_ex_load;
  logic w_src_match;

  // x0 is hard-wired zero, so a load targeting it can never be a dependency.
  assign w_ex_load   = ex_valid_i && ex_read_i && (ex_rd_i != 5'd0);
  assign w_src_match = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
  assign load_use_o  = w_ex_load && id_valid_i && w_src_match;

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// Module : id_ex_reg
// ID/EX pipeline register with load-use bubbles, flush, and an optional
// multi-cycle multiply hold enabled by the MUL_STALL_EN macro.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_reg
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  ctrl_t           id_ctrl_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [XLEN-1:0] id_rd1_i,
  input  logic [XLEN-1:0] id_rd2_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_pc4_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output ctrl_t           ex_ctrl_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [XLEN-1:0] ex_rd1_o,
  output logic [XLEN-1:0] ex_rd2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_pc4_o,
  output logic [2:0]      ex_funct3_o,
  output logic            stall_o,
  output logic            mul_busy_o
);

  if ((MUL_LAT < 1) || (MUL_LAT > 8)) begin : g_mul_lat_check
    $error("id_ex_reg: MUL_LAT must be within 1..8");
  end

  localparam logic [1:0] SEL_LOAD   = 2'd0;
  localparam logic [1:0] SEL_HOLD   = 2'd1;
  localparam logic [1:0] SEL_BUBBLE = 2'd2;

  logic            valid_q,  valid_d;
  ctrl_t           ctrl_q,   ctrl_d;
  logic [4:0]      rs1_q,    rs1_d;
  logic [4:0]      rs2_q,    rs2_d;
  logic [4:0]      rd_q,     rd_d;
  logic [XLEN-1:0] rd1_q,    rd1_d;
  logic [XLEN-1:0] rd2_q,    rd2_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] pc4_q,    pc4_d;
  logic [2:0]      funct3_q, funct3_d;

  logic       w_load_use;
  logic       w_mul_hold;
  logic [1:0] w_sel;

  hazard_detect u_hazard_detect (
    .ex_valid_i (valid_q),
    .ex_read_i  (ctrl_q.read),
    .ex_rd_i    (rd_q),
    .id_valid_i (id_valid_i),
    .id_rs1_i   (id_rs1_i),
    .id_rs2_i   (id_rs2_i),
    .load_use_o (w_load_use)
  );

`ifdef MUL_STALL_EN
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;
  localparam int         CNT_W      = 3;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             w_mul_start;

  assign w_mul_hold  = (state_q == S_MUL_BUSY);
  assign w_mul_start = id_valid_i && is_mul(id_ctrl_i.aluCtrl) && (MUL_LAT > 1);

  // A multiply that just entered EX has already spent one cycle there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (w_mul_hold) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (!w_load_use && w_mul_start) begin
      state_d = S_MUL_BUSY;
      cnt_d   = CNT_W'(MUL_LAT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_busy_o = w_mul_hold;
`else
  assign w_mul_hold = 1'b0;
  assign mul_busy_o = 1'b0;
`endif

  always_comb begin
    w_sel = SEL_LOAD;
    if (flush_i) begin
      w_sel = SEL_BUBBLE;
    end else if (w_mul_hold) begin
      w_sel = SEL_HOLD;
    end else if (w_load_use) begin
      w_sel = SEL_BUBBLE;
    end
  end

  assign stall_o = !flush_i && (w_mul_hold || w_load_use);

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    funct3_d = funct3_q;
    case (w_sel)
      SEL_LOAD: begin
        valid_d  = id_valid_i;
        ctrl_d   = id_ctrl_i;
        rs1_d    = id_rs1_i;
        rs2_d    = id_rs2_i;
        rd_d     = id_rd_i;
        rd1_d    = id_rd1_i;
        rd2_d    = id_rd2_i;
        imm_d    = id_imm_i;
        pc_d     = id_pc_i;
        pc4_d    = id_pc4_i;
        funct3_d = id_funct3_i;
      end
      SEL_BUBBLE: begin
        valid_d  = 1'b0;
        ctrl_d   = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
        pc_d     = '0;
        pc4_d    = '0;
        funct3_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      pc4_q    <= '0;
      funct3_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      funct3_q <= funct3_d;
    end
  end

  assign ex_valid_o  = valid_q;
  assign ex_ctrl_o   = ctrl_q;
  assign ex_rs1_o    = rs1_q;
  assign ex_rs2_o    = rs2_q;
  assign ex_rd_o     = rd_q;
  assign ex_rd1_o    = rd1_q;
  assign ex_rd2_o    = rd2_q;
  assign ex_imm_o    = imm_q;
  assign ex_pc_o     = pc_q;
  assign ex_pc4_o    = pc4_q;
  assign ex_funct3_o = funct3_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module : tb_id_ex_reg
// Directed bench for id_ex_reg; multiply-hold vectors follow MUL_STALL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_reg;
  import core_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            id_valid_i = 1'b0;
  ctrl_t           id_ctrl_i = '0;
  logic [4:0]      id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic [XLEN-1:0] id_rd1_i = '0, id_rd2_i = '0, id_imm_i = '0, id_pc_i = '0, id_pc4_i = '0;
  logic [2:0]      id_funct3_i = '0;
  logic            flush_i = 1'b0;
  logic            ex_valid_o;
  ctrl_t           ex_ctrl_o;
  logic [4:0]      ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [XLEN-1:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o, ex_pc4_o;
  logic [2:0]      ex_funct3_o;
  logic            stall_o, mul_busy_o;

  int n_vec = 0;
  int n_err = 0;

  id_ex_reg #(.XLEN(XLEN), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
    .id_pc_i(id_pc_i), .id_pc4_i(id_pc4_i), .id_funct3_i(id_funct3_i),
    .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
    .ex_pc_o(ex_pc_o), .ex_pc4_o(ex_pc4_o), .ex_funct3_o(ex_funct3_o),
    .stall_o(stall_o), .mul_busy_o(mul_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand fields are derived from the register numbers so loads are traceable.
  task automatic drive(input logic v, input ctrl_t c, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    id_valid_i  = v;
    id_ctrl_i   = c;
    id_rs1_i    = rs1;
    id_rs2_i    = rs2;
    id_rd_i     = rd;
    id_rd1_i    = 32'hA000_0000 | 32'(rs1);
    id_rd2_i    = 32'hB000_0000 | 32'(rs2);
    id_imm_i    = 32'h0000_0100 | 32'(rd);
    id_pc_i     = 32'h0000_1000 + 32'(rd);
    id_pc4_i    = 32'h0000_1004 + 32'(rd);
    id_funct3_i = 3'(rd);
  endtask

  function automatic ctrl_t alu_op(input logic [4:0] alu);
    ctrl_t c;
    c = '0;
    c.regWrt  = 1'b1;
    c.aluCtrl = alu;
    return c;
  endfunction

  function automatic ctrl_t load_op();
    ctrl_t c;
    c = '0;
    c.regWrt  = 1'b1;
    c.aluSrc  = 1'b1;
    c.read    = 1'b1;
    c.rsltSrc = 2'b01;
    return c;
  endfunction

  initial begin
    ctrl_t dc;
    drive(1'b1, alu_op(5'd0), 5'd1, 5'd2, 5'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_rd", 32'(ex_rd_o), 32'd0);
    chk("rst_ctrl", 32'(ex_ctrl_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_busy", 32'(mul_busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_valid", 32'(ex_valid_o), 32'd0);

    // add x3,x1,x2
    tick();
    chk("add_rd", 32'(ex_rd_o), 32'd3);
    chk("add_regwrt", 32'(ex_ctrl_o.regWrt), 32'd1);
    chk("add_valid", 32'(ex_valid_o), 32'd1);
    chk("add_rd1", ex_rd1_o, 32'hA000_0001);
    chk("add_pc4", ex_pc4_o, 32'h0000_1007);
    chk("add_stall", 32'(stall_o), 32'd0);

    // lw x5 then add x6,x5,x7
    drive(1'b1, load_op(), 5'd1, 5'd0, 5'd5);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd5, 5'd7, 5'd6);
    #1 chk("lu_stall", 32'(stall_o), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(ex_valid_o), 32'd0);
    chk("lu_bub_ctrl", 32'(ex_ctrl_o), 32'd0);
    chk("lu_bub_rd", 32'(ex_rd_o), 32'd0);
    chk("lu_bub_rd1", ex_rd1_o, 32'd0);
    chk("lu_stall_off", 32'(stall_o), 32'd0);
    tick();
    chk("lu_add_rd", 32'(ex_rd_o), 32'd6);
    chk("lu_add_valid", 32'(ex_valid_o), 32'd1);
    chk("lu_add_rs1", 32'(ex_rs1_o), 32'd5);

    // lw x0 then add x8,x0,x0
    drive(1'b1, load_op(), 5'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd0, 5'd0, 5'd8);
    #1 chk("x0_stall", 32'(stall_o), 32'd0);
    tick();
    chk("x0_rd", 32'(ex_rd_o), 32'd8);
    chk("x0_valid", 32'(ex_valid_o), 32'd1);

    // lw x9 then sub x12,x1,x9 (rs2 match)
    drive(1'b1, load_op(), 5'd1, 5'd0, 5'd9);
    tick();
    drive(1'b1, alu_op(5'd1), 5'd1, 5'd9, 5'd12);
    #1 chk("rs2_stall", 32'(stall_o), 32'd1);
    tick();
    chk("rs2_bub_valid", 32'(ex_valid_o), 32'd0);
    tick();
    chk("rs2_sub_rd", 32'(ex_rd_o), 32'd12);

    // invalid ID slot reading the load target
    drive(1'b1, load_op(), 5'd1, 5'd0, 5'd9);
    tick();
    drive(1'b0, alu_op(5'd0), 5'd9, 5'd9, 5'd13);
    #1 chk("inv_stall", 32'(stall_o), 32'd0);
    tick();
    chk("inv_valid", 32'(ex_valid_o), 32'd0);
    chk("inv_rd", 32'(ex_rd_o), 32'd13);

    // flush coincident with load-use
    drive(1'b1, load_op(), 5'd1, 5'd0, 5'd5);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd5, 5'd7, 5'd6);
    flush_i = 1'b1;
    #1 chk("fl_stall", 32'(stall_o), 32'd0);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", 32'(ex_valid_o), 32'd0);
    chk("fl_rd", 32'(ex_rd_o), 32'd0);

    // arbitrary ctrl pattern registered unchanged
    dc = ctrl_t'(15'h5A5A);
    drive(1'b1, dc, 5'd2, 5'd3, 5'd14);
    tick();
    chk("dc_ctrl", 32'(ex_ctrl_o), 32'h5A5A);

    // aluCtrl just above the multiply range
    drive(1'b1, alu_op(5'b01110), 5'd1, 5'd2, 5'd15);
    tick();
    chk("nm_busy", 32'(mul_busy_o), 32'd0);
    chk("nm_rd", 32'(ex_rd_o), 32'd15);

    // mul x4 followed by add x10
    drive(1'b1, alu_op(ALU_MUL), 5'd1, 5'd2, 5'd4);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd1, 5'd2, 5'd10);
    #1;
`ifdef MUL_STALL_EN
    chk("mul_c1_stall", 32'(stall_o), 32'd1);
    chk("mul_c1_busy", 32'(mul_busy_o), 32'd1);
    chk("mul_c1_rd", 32'(ex_rd_o), 32'd4);
    tick();
    chk("mul_c2_stall", 32'(stall_o), 32'd1);
    chk("mul_c2_busy", 32'(mul_busy_o), 32'd1);
    chk("mul_c2_rd", 32'(ex_rd_o), 32'd4);
    chk("mul_c2_rd1", ex_rd1_o, 32'hA000_0001);
    tick();
    chk("mul_c3_stall", 32'(stall_o), 32'd0);
    chk("mul_c3_busy", 32'(mul_busy_o), 32'd0);
    chk("mul_c3_rd", 32'(ex_rd_o), 32'd4);
    tick();
    chk("mul_next_rd", 32'(ex_rd_o), 32'd10);

    // flush while the multiply holds EX
    drive(1'b1, alu_op(ALU_MULHU), 5'd1, 5'd2, 5'd4);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd1, 5'd2, 5'd10);
    flush_i = 1'b1;
    #1 chk("mfl_stall", 32'(stall_o), 32'd0);
    chk("mfl_busy_pre", 32'(mul_busy_o), 32'd1);
    tick();
    flush_i = 1'b0;
    chk("mfl_valid", 32'(ex_valid_o), 32'd0);
    chk("mfl_busy", 32'(mul_busy_o), 32'd0);
    tick();
    chk("mfl_next_rd", 32'(ex_rd_o), 32'd10);
`else
    chk("mul_stall", 32'(stall_o), 32'd0);
    chk("mul_busy", 32'(mul_busy_o), 32'd0);
    chk("mul_rd", 32'(ex_rd_o), 32'd4);
    tick();
    chk("mul_next_rd", 32'(ex_rd_o), 32'd10);
`endif

    // reset while a multiply sits in EX
    drive(1'b1, alu_op(ALU_MULH), 5'd1, 5'd2, 5'd4);
    tick();
    drive(1'b1, alu_op(5'd0), 5'd1, 5'd2, 5'd11);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(ex_valid_o), 32'd0);
    chk("mrst_rd", 32'(ex_rd_o), 32'd0);
    chk("mrst_ctrl", 32'(ex_ctrl_o), 32'd0);
    chk("mrst_busy", 32'(mul_busy_o), 32'd0);
    chk("mrst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rd", 32'(ex_rd_o), 32'd11);
    chk("post_valid", 32'(ex_valid_o), 32'd1);
    chk("post_busy", 32'(mul_busy_o), 32'd0);
    chk("post_stall", 32'(stall_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
